// File: rtl/degamma_lut_init_loader.sv
// degamma_lut_init_loader: copies the rom0/rom1 degamma init tables into the degamma LUT write port.
// Latency: 3 cycles per entry (fetch, latch, push) with i_wr_ready high; o_done pulses 1 cycle after the last accept.
// Backpressure: o_wr_* held stable while o_wr_valid & ~i_wr_ready; i_start ignored unless idle.
// Optional build: `define DEGAMMA_INIT_MONO_CHK_EN adds the sticky table-monotonicity check on o_mono_err.
module degamma_lut_init_loader #(
  parameter int A_BW       = 7,
  parameter int D_BW       = 12,
  parameter int N_ENTRY    = 65,   // must satisfy N_ENTRY <= 2**A_BW
  parameter bit AUTO_START = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  output logic            o_rom_cen,
  output logic [A_BW-1:0] o_rom_a,
  input  logic [D_BW-1:0] i_rom0_q,
  input  logic [D_BW-1:0] i_rom1_q,
  output logic            o_wr_valid,
  input  logic            i_wr_ready,
  output logic [A_BW-1:0] o_wr_addr,
  output logic [D_BW-1:0] o_wr_data0,
  output logic [D_BW-1:0] o_wr_data1,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_mono_err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_PUSH, S_DONE} state_t;

  localparam logic [A_BW-1:0] LAST_IDX = A_BW'(N_ENTRY - 1);

  state_t          r_state;
  logic [A_BW-1:0] r_idx;
  logic            r_auto;      // pending automatic start, armed only by reset
  logic            r_rom_cen;
  logic [A_BW-1:0] r_rom_a;
  logic            r_wr_valid;
  logic [A_BW-1:0] r_wr_addr;
  logic [D_BW-1:0] r_wr_data0;
  logic [D_BW-1:0] r_wr_data1;
  logic            r_busy;
  logic            r_done;
  logic            w_last;

  assign w_last = (r_idx == LAST_IDX);

`ifdef DEGAMMA_INIT_MONO_CHK_EN
  logic r_mono_err;
  logic w_mono_viol;

  // Table check on the pair being latched; the previous pair still sits in the write-data registers
  always_comb begin
    w_mono_viol = (i_rom1_q < i_rom0_q);
    if (r_idx != '0) begin
      w_mono_viol = w_mono_viol || (i_rom0_q < r_wr_data0) || (i_rom1_q < r_wr_data1);
    end
  end

  assign o_mono_err = r_mono_err;
`else
  assign o_mono_err = 1'b0;
`endif

  // Load sequencer: walks idx through fetch/latch/push and owns every registered output
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_auto     <= AUTO_START;
      r_rom_cen  <= 1'b1;
      r_rom_a    <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data0 <= '0;
      r_wr_data1 <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DEGAMMA_INIT_MONO_CHK_EN
      r_mono_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start || r_auto) begin
            r_auto    <= 1'b0;
            r_state   <= S_FETCH;
            r_rom_cen <= 1'b0;
            r_rom_a   <= r_idx;
            r_busy    <= 1'b1;
`ifdef DEGAMMA_INIT_MONO_CHK_EN
            // a fresh load clears the previous load's verdict
            if (r_idx == '0) r_mono_err <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          r_rom_cen <= 1'b1;
          r_state   <= S_LATCH;
        end
        S_LATCH: begin
          r_wr_data0 <= i_rom0_q;
          r_wr_data1 <= i_rom1_q;
          r_wr_addr  <= r_idx;
          r_wr_valid <= 1'b1;
          r_state    <= S_PUSH;
`ifdef DEGAMMA_INIT_MONO_CHK_EN
          if (w_mono_viol) r_mono_err <= 1'b1;
`endif
        end
        S_PUSH: begin
          if (i_wr_ready) begin
            r_wr_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_rom_a   <= r_idx + 1'b1;
              r_rom_cen <= 1'b0;
              r_state   <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rom_cen  = r_rom_cen;
  assign o_rom_a    = r_rom_a;
  assign o_wr_valid = r_wr_valid;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data0 = r_wr_data0;
  assign o_wr_data1 = r_wr_data1;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_degamma_lut_init_loader.sv
// Bench for degamma_lut_init_loader: ROM pair model, randomized LUT backpressure, table-level reference model.
module tb_degamma_lut_init_loader;

  localparam int N = 65;
`ifdef DEGAMMA_INIT_MONO_CHK_EN
  localparam bit MONO_EN = 1'b1;
`else
  localparam bit MONO_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_wr_ready = 1'b1;
  logic [11:0] i_rom0_q = '0;
  logic [11:0] i_rom1_q = '0;
  logic        o_rom_cen;
  logic [6:0]  o_rom_a;
  logic        o_wr_valid;
  logic [6:0]  o_wr_addr;
  logic [11:0] o_wr_data0;
  logic [11:0] o_wr_data1;
  logic        o_busy;
  logic        o_done;
  logic        o_mono_err;

  int checks = 0;
  int errors = 0;
  int range_bad = 0;

  // ROM contents and reference expectations
  logic [11:0] t0 [N];
  logic [11:0] t1 [N];
  logic [11:0] exp_d0 [$];
  logic [11:0] exp_d1 [$];
  logic        exp_mono [$];
  logic        exp_mono_final;

  // observations from the last load
  int          acc_cyc [$];
  logic [6:0]  acc_addr [$];
  logic [11:0] acc_d0 [$];
  logic [11:0] acc_d1 [$];
  logic        acc_mono [$];
  int          done_cnt, done_cyc, hold_bad, quiet_bad;
  logic        mono_at_done, busy_at_done;
  bit          aborted;

  degamma_lut_init_loader #(.A_BW(7), .D_BW(12), .N_ENTRY(N), .AUTO_START(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .o_rom_cen(o_rom_cen), .o_rom_a(o_rom_a), .i_rom0_q(i_rom0_q), .i_rom1_q(i_rom1_q),
    .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr),
    .o_wr_data0(o_wr_data0), .o_wr_data1(o_wr_data1),
    .o_busy(o_busy), .o_done(o_done), .o_mono_err(o_mono_err)
  );

  always #5 i_clk = ~i_clk;

  // registered-read ROM pair sharing one enable and address
  always @(posedge i_clk) begin
    if (o_rom_cen === 1'b0) begin
      if (int'(o_rom_a) < N) begin
        i_rom0_q <= t0[o_rom_a];
        i_rom1_q <= t1[o_rom_a];
      end else begin
        i_rom0_q <= 'x;
        i_rom1_q <= 'x;
      end
    end
  end

  // the ROM must never be enabled beyond the last entry
  always @(posedge i_clk) begin
    if (o_rom_cen === 1'b0 && int'(o_rom_a) >= N) range_bad++;
  end

  // piecewise-linear monotone curves through (0,2), (819,848) at 31 and (4057,4095) at 64
  function automatic void build_tables(input bit corrupt);
    for (int k = 0; k < N; k++) begin
      if (k <= 31) begin
        t0[k] = 12'((819 * k) / 31);
        t1[k] = 12'(2 + (846 * k) / 31);
      end else begin
        t0[k] = 12'(819 + ((4057 - 819) * (k - 31)) / 33);
        t1[k] = 12'(848 + ((4095 - 848) * (k - 31)) / 33);
      end
    end
    if (corrupt) t0[20] = 12'd200;
  endfunction

  // expected write stream: each entry passes through untouched; the error flag is the running
  // OR of table-rule violations seen so far in this load (only when the check is built in)
  function automatic void build_model();
    bit viol = 1'b0;
    exp_d0.delete(); exp_d1.delete(); exp_mono.delete();
    for (int k = 0; k < N; k++) begin
      if (t1[k] < t0[k]) viol = 1'b1;
      if (k > 0 && (t0[k] < t0[k-1] || t1[k] < t1[k-1])) viol = 1'b1;
      exp_d0.push_back(t0[k]);
      exp_d1.push_back(t1[k]);
      exp_mono.push_back(MONO_EN && viol);
    end
    exp_mono_final = MONO_EN && viol;
  endfunction

  // Drives one load (kick=1 pulses start, else relies on auto start) and records what the LUT port saw.
  // Cycle 0 is the call-time negedge; the next posedge is edge 0. mode 0: ready high, 1: ready on
  // every third valid cycle, 2: random ready. abort_addr >= 0 asserts reset in PUSH of that entry.
  task automatic collect(input int mode, input bit kick, input bit extra_starts, input int abort_addr);
    int cyc = 0;
    int vcnt = 0;
    bit held = 1'b0;
    logic rdy;
    logic [6:0] h_a;
    logic [11:0] h_0, h_1;
    acc_cyc.delete(); acc_addr.delete(); acc_d0.delete(); acc_d1.delete(); acc_mono.delete();
    done_cnt = 0; done_cyc = -1; hold_bad = 0; quiet_bad = 0; aborted = 1'b0;
    mono_at_done = 1'bx; busy_at_done = 1'bx;
    if (kick) i_start = 1'b1;
    while (cyc < 1500 && done_cnt == 0 && !aborted) begin
      @(negedge i_clk);
      cyc++;
      i_start = 1'b0;
      if (held && !(o_wr_valid === 1'b1 && o_wr_addr === h_a && o_wr_data0 === h_0 && o_wr_data1 === h_1))
        hold_bad++;
      held = 1'b0;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = o_wr_valid ? ((vcnt % 3) == 2) : 1'($urandom_range(0, 1));
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (o_wr_valid === 1'b1) vcnt++;
      i_wr_ready = rdy;
      if (o_wr_valid === 1'b1 && int'(o_wr_addr) == abort_addr) begin
        i_rst = 1'b1;
        aborted = 1'b1;
      end else begin
        if (o_wr_valid === 1'b1 && rdy) begin
          acc_cyc.push_back(cyc);
          acc_addr.push_back(o_wr_addr);
          acc_d0.push_back(o_wr_data0);
          acc_d1.push_back(o_wr_data1);
          acc_mono.push_back(o_mono_err);
          if (extra_starts && o_wr_addr == 7'd10) i_start = 1'b1;
        end else if (o_wr_valid === 1'b1) begin
          held = 1'b1; h_a = o_wr_addr; h_0 = o_wr_data0; h_1 = o_wr_data1;
        end
        if (o_done === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
          mono_at_done = o_mono_err;
          busy_at_done = o_busy;
          if (extra_starts) i_start = 1'b1;
        end
      end
    end
    if (!aborted) begin
      // after done the block must stay idle: no queued start, no extra write or done
      for (int q = 0; q < 30; q++) begin
        @(negedge i_clk);
        i_start = 1'b0;
        i_wr_ready = 1'($urandom_range(0, 1));
        if (o_busy !== 1'b0 || o_wr_valid !== 1'b0 || o_rom_cen !== 1'b1) quiet_bad++;
        if (o_done === 1'b1) done_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++; if (o_rom_cen !== 1'b1) begin errors++; $display("FAIL reset rom_cen: got %b expected 1", o_rom_cen); end
    checks++; if (o_rom_a !== 7'd0) begin errors++; $display("FAIL reset rom_a: got %0d expected 0", o_rom_a); end
    checks++; if (o_wr_valid !== 1'b0) begin errors++; $display("FAIL reset wr_valid: got %b expected 0", o_wr_valid); end
    checks++; if (o_wr_addr !== 7'd0) begin errors++; $display("FAIL reset wr_addr: got %0d expected 0", o_wr_addr); end
    checks++; if (o_wr_data0 !== 12'd0 || o_wr_data1 !== 12'd0) begin
      errors++; $display("FAIL reset wr_data: got %0d/%0d expected 0/0", o_wr_data0, o_wr_data1); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", o_done); end
    checks++; if (o_mono_err !== 1'b0) begin errors++; $display("FAIL reset mono_err: got %b expected 0", o_mono_err); end
  endtask

  task automatic test_auto_start();
    build_tables(1'b0);
    build_model();
    i_rst = 1'b0;
    collect(0, 1'b0, 1'b0, -1);
    checks++;
    if (acc_addr.size() !== N) begin errors++; $display("FAIL auto write count: got %0d expected %0d", acc_addr.size(), N); end
    for (int k = 0; k < acc_addr.size() && k < N; k++) begin
      checks++;
      if (acc_addr[k] !== 7'(k) || acc_d0[k] !== exp_d0[k] || acc_d1[k] !== exp_d1[k] ||
          acc_mono[k] !== exp_mono[k] || acc_cyc[k] != 3 * k + 3) begin
        errors++;
        $display("FAIL auto entry %0d: got addr=%0d d=(%0d,%0d) mono=%b cyc=%0d expected addr=%0d d=(%0d,%0d) mono=%b cyc=%0d",
                 k, acc_addr[k], acc_d0[k], acc_d1[k], acc_mono[k], acc_cyc[k], k, exp_d0[k], exp_d1[k], exp_mono[k], 3 * k + 3);
      end
    end
    if (acc_addr.size() == N) begin
      checks++;
      if (acc_d0[0] !== 12'd0 || acc_d1[0] !== 12'd2 || acc_d0[31] !== 12'd819 || acc_d1[31] !== 12'd848 ||
          acc_d0[64] !== 12'd4057 || acc_d1[64] !== 12'd4095) begin
        errors++;
        $display("FAIL auto golden points: got (%0d,%0d) (%0d,%0d) (%0d,%0d) expected (0,2) (819,848) (4057,4095)",
                 acc_d0[0], acc_d1[0], acc_d0[31], acc_d1[31], acc_d0[64], acc_d1[64]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL auto done count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc != 196) begin errors++; $display("FAIL auto done cycle: got %0d expected 196", done_cyc); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL auto busy at done: got %b expected 0", busy_at_done); end
    checks++; if (quiet_bad != 0) begin errors++; $display("FAIL auto idle after done: got %0d busy cycles expected 0", quiet_bad); end
  endtask

  task automatic test_backpressure();
    for (int m = 1; m <= 2; m++) begin
      collect(m, 1'b1, 1'b0, -1);
      checks++;
      if (acc_addr.size() !== N) begin errors++; $display("FAIL bp%0d write count: got %0d expected %0d", m, acc_addr.size(), N); end
      for (int k = 0; k < acc_addr.size() && k < N; k++) begin
        checks++;
        if (acc_addr[k] !== 7'(k) || acc_d0[k] !== exp_d0[k] || acc_d1[k] !== exp_d1[k] || acc_mono[k] !== exp_mono[k]) begin
          errors++;
          $display("FAIL bp%0d entry %0d: got addr=%0d d=(%0d,%0d) mono=%b expected addr=%0d d=(%0d,%0d) mono=%b",
                   m, k, acc_addr[k], acc_d0[k], acc_d1[k], acc_mono[k], k, exp_d0[k], exp_d1[k], exp_mono[k]);
        end
      end
      checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp%0d hold stability: got %0d unstable cycles expected 0", m, hold_bad); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp%0d done count: got %0d expected 1", m, done_cnt); end
      checks++; if (quiet_bad != 0) begin errors++; $display("FAIL bp%0d idle after done: got %0d expected 0", m, quiet_bad); end
    end
  endtask

  task automatic test_start_ignored();
    collect(2, 1'b1, 1'b1, -1);
    checks++;
    if (acc_addr.size() !== N) begin errors++; $display("FAIL restart write count: got %0d expected %0d", acc_addr.size(), N); end
    for (int k = 0; k < acc_addr.size() && k < N; k++) begin
      checks++;
      if (acc_addr[k] !== 7'(k) || acc_d0[k] !== exp_d0[k] || acc_d1[k] !== exp_d1[k]) begin
        errors++;
        $display("FAIL restart entry %0d: got addr=%0d d=(%0d,%0d) expected addr=%0d d=(%0d,%0d)",
                 k, acc_addr[k], acc_d0[k], acc_d1[k], k, exp_d0[k], exp_d1[k]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart done count: got %0d expected 1", done_cnt); end
    checks++; if (quiet_bad != 0) begin errors++; $display("FAIL restart start queued: got %0d busy cycles expected 0", quiet_bad); end
  endtask

  task automatic test_reset_mid_load();
    collect(0, 1'b1, 1'b0, 40);
    checks++; if (!aborted) begin errors++; $display("FAIL abort reached entry 40: got 0 expected 1"); end
    checks++; if (acc_addr.size() !== 40) begin errors++; $display("FAIL abort writes before reset: got %0d expected 40", acc_addr.size()); end
    @(negedge i_clk);
    checks++;
    if (o_wr_valid !== 1'b0 || o_busy !== 1'b0 || o_rom_cen !== 1'b1 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL abort outputs: got valid=%b busy=%b cen=%b done=%b expected 0 0 1 0", o_wr_valid, o_busy, o_rom_cen, o_done);
    end
    i_rst = 1'b0;
    collect(0, 1'b0, 1'b0, -1);
    checks++;
    if (acc_addr.size() !== N) begin errors++; $display("FAIL abort reload count: got %0d expected %0d", acc_addr.size(), N); end
    for (int k = 0; k < acc_addr.size() && k < N; k++) begin
      checks++;
      if (acc_addr[k] !== 7'(k) || acc_d0[k] !== exp_d0[k] || acc_d1[k] !== exp_d1[k] || acc_cyc[k] != 3 * k + 3) begin
        errors++;
        $display("FAIL abort reload entry %0d: got addr=%0d d=(%0d,%0d) cyc=%0d expected addr=%0d d=(%0d,%0d) cyc=%0d",
                 k, acc_addr[k], acc_d0[k], acc_d1[k], acc_cyc[k], k, exp_d0[k], exp_d1[k], 3 * k + 3);
      end
    end
    checks++; if (done_cyc != 196) begin errors++; $display("FAIL abort reload done cycle: got %0d expected 196", done_cyc); end
  endtask

  task automatic test_mono_table();
    build_tables(1'b1);
    build_model();
    collect(2, 1'b1, 1'b0, -1);
    checks++;
    if (acc_addr.size() !== N) begin errors++; $display("FAIL mono write count: got %0d expected %0d", acc_addr.size(), N); end
    for (int k = 0; k < acc_addr.size() && k < N; k++) begin
      checks++;
      if (acc_addr[k] !== 7'(k) || acc_d0[k] !== exp_d0[k] || acc_d1[k] !== exp_d1[k] || acc_mono[k] !== exp_mono[k]) begin
        errors++;
        $display("FAIL mono entry %0d: got addr=%0d d=(%0d,%0d) mono=%b expected addr=%0d d=(%0d,%0d) mono=%b",
                 k, acc_addr[k], acc_d0[k], acc_d1[k], acc_mono[k], k, exp_d0[k], exp_d1[k], exp_mono[k]);
      end
    end
    if (acc_d0.size() > 20) begin
      checks++; if (acc_d0[20] !== 12'd200) begin errors++; $display("FAIL mono corrupted value: got %0d expected 200", acc_d0[20]); end
    end
    checks++;
    if (mono_at_done !== exp_mono_final) begin
      errors++; $display("FAIL mono at done: got %b expected %b", mono_at_done, exp_mono_final);
    end
    // golden table again: the flag must clear at the start of the new load and stay low
    build_tables(1'b0);
    build_model();
    collect(0, 1'b1, 1'b0, -1);
    checks++;
    if (acc_mono.size() !== N) begin errors++; $display("FAIL golden write count: got %0d expected %0d", acc_mono.size(), N); end
    for (int k = 0; k < acc_mono.size() && k < N; k++) begin
      checks++;
      if (acc_mono[k] !== 1'b0 || acc_d0[k] !== exp_d0[k]) begin
        errors++; $display("FAIL golden entry %0d: got mono=%b d0=%0d expected mono=0 d0=%0d", k, acc_mono[k], acc_d0[k], exp_d0[k]);
      end
    end
    checks++; if (mono_at_done !== 1'b0) begin errors++; $display("FAIL golden mono at done: got %b expected 0", mono_at_done); end
  endtask

  initial begin
    build_tables(1'b0);
    build_model();
    test_reset();
    test_auto_start();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_load();
    test_mono_table();
    checks++;
    if (range_bad != 0) begin errors++; $display("FAIL rom address range: got %0d out-of-range reads expected 0", range_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
